// File: rtl/sort_pkg.sv
// Shared defaults, parameter legality checks and stage-count helper for the
// odd-even transposition sorter.
package sort_pkg;
    localparam int DATA_W_DEF = 8;
    localparam int N_DEF      = 3;
    localparam int N_MIN      = 3;
    localparam int N_MAX      = 9;
    localparam int W_MIN      = 2;
    localparam int W_MAX      = 16;

    function automatic bit n_legal(input int n);
        return (n >= N_MIN) && (n <= N_MAX) && (n % 2 == 1);
    endfunction

    function automatic bit w_legal(input int w);
        return (w >= W_MIN) && (w <= W_MAX);
    endfunction

    // An odd-even transposition network needs as many stages as elements.
    function automatic int stage_count(input int n);
        return n;
    endfunction
endpackage

// File: rtl/sortn_pipe_if.sv
// Valid/ready window-in, sorted-result-out bundle for sortn_pipe.
import sort_pkg::*;

interface sortn_pipe_if #(
    parameter int DATA_W = DATA_W_DEF,
    parameter int N      = N_DEF
);
    logic                in_valid;
    logic                in_ready;
    logic [N*DATA_W-1:0] in_data;
    logic                in_desc;
    logic                out_valid;
    logic                out_ready;
    logic [N*DATA_W-1:0] out_data;
    logic [DATA_W-1:0]   out_min;
    logic [DATA_W-1:0]   out_med;
    logic [DATA_W-1:0]   out_max;

    modport master (
        output in_valid, in_data, in_desc, out_ready,
        input  in_ready, out_valid, out_data, out_min, out_med, out_max
    );

    modport slave (
        input  in_valid, in_data, in_desc, out_ready,
        output in_ready, out_valid, out_data, out_min, out_med, out_max
    );
endinterface

// File: rtl/cmp_swap.sv
// Combinational compare-exchange: x/y get the ordered pair; equal inputs
// never swap.
module cmp_swap #(
    parameter int DATA_W = 8
) (
    input  logic              desc,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] x,
    output logic [DATA_W-1:0] y
);
    logic swap;

    always_comb begin
        swap = desc ? (a < b) : (a > b);
        x    = swap ? b : a;
        y    = swap ? a : b;
    end
endmodule

// File: rtl/sortn_pipe.sv
// Fully pipelined N-stage odd-even transposition sorter with valid/ready
// handshake, per-window order bit, and min/median/max taps.
module sortn_pipe
    import sort_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int N          = N_DEF,
    parameter int DESCEND_EN = 1
) (
    input logic         clk,
    input logic         rst,
    sortn_pipe_if.slave bus
);
    localparam int S = stage_count(N);

    typedef logic [N-1:0][DATA_W-1:0] vec_t;

    if (!n_legal(N)) begin : g_bad_n
        $error("sortn_pipe: N must be odd and within 3..9");
    end
    if (!w_legal(DATA_W)) begin : g_bad_w
        $error("sortn_pipe: DATA_W must be within 2..16");
    end

    vec_t           src [S];
    vec_t           nxt [S];
    vec_t           q   [S];
    logic [S-1:0]   vld;
    logic [S-1:0]   dsc;
    logic [S-1:0]   dsc_in;
    logic           advance;

    assign advance      = !vld[S-1] || bus.out_ready;
    assign bus.in_ready = advance;

    assign src[0] = bus.in_data;
    if (DESCEND_EN != 0) begin : g_desc
        assign dsc_in[0] = bus.in_desc;
    end else begin : g_asc_only
        assign dsc_in[0] = 1'b0;
    end

    for (genvar s = 1; s < S; s++) begin : g_link
        assign src[s]    = q[s-1];
        assign dsc_in[s] = dsc[s-1];
    end

    // Even stages leave the top element unpaired, odd stages leave element 0.
    for (genvar s = 0; s < S; s++) begin : g_stage
        for (genvar p = s % 2; p + 1 < N; p += 2) begin : g_cmp
            cmp_swap #(.DATA_W(DATA_W)) u_cmp (
                .desc (dsc_in[s]),
                .a    (src[s][p]),
                .b    (src[s][p+1]),
                .x    (nxt[s][p]),
                .y    (nxt[s][p+1])
            );
        end
        if (s % 2 == 0) begin : g_pass_top
            assign nxt[s][N-1] = src[s][N-1];
        end else begin : g_pass_bot
            assign nxt[s][0] = src[s][0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned s = 0; s < S; s++) begin
                q[s] <= '0;
            end
            vld <= '0;
            dsc <= '0;
        end else if (advance) begin
            for (int unsigned s = 0; s < S; s++) begin
                q[s] <= nxt[s];
            end
            vld <= {vld[S-2:0], bus.in_valid};
            dsc <= dsc_in;
        end
    end

    assign bus.out_valid = vld[S-1];
    assign bus.out_data  = q[S-1];
    assign bus.out_med   = q[S-1][(N-1)/2];
    assign bus.out_min   = dsc[S-1] ? q[S-1][N-1] : q[S-1][0];
    assign bus.out_max   = dsc[S-1] ? q[S-1][0]   : q[S-1][N-1];
endmodule

// File: tb/tb_sortn_pipe.sv
// Directed and scoreboarded checks of sortn_pipe at N=3, 5 and 9.
module tb_sortn_pipe;
    import sort_pkg::*;

    typedef struct packed {
        logic [71:0] data;
        logic [7:0]  mn;
        logic [7:0]  md;
        logic [7:0]  mx;
    } res_t;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    sortn_pipe_if #(.DATA_W(8), .N(3)) if3  ();
    sortn_pipe_if #(.DATA_W(8), .N(3)) if3n ();
    sortn_pipe_if #(.DATA_W(8), .N(5)) if5  ();
    sortn_pipe_if #(.DATA_W(8), .N(9)) if9  ();

    sortn_pipe #(.DATA_W(8), .N(3), .DESCEND_EN(1)) u_dut3  (.clk(clk), .rst(rst), .bus(if3.slave));
    sortn_pipe #(.DATA_W(8), .N(3), .DESCEND_EN(0)) u_dut3n (.clk(clk), .rst(rst), .bus(if3n.slave));
    sortn_pipe #(.DATA_W(8), .N(5), .DESCEND_EN(1)) u_dut5  (.clk(clk), .rst(rst), .bus(if5.slave));
    sortn_pipe #(.DATA_W(8), .N(9), .DESCEND_EN(1)) u_dut9  (.clk(clk), .rst(rst), .bus(if9.slave));

    // The ascending-only instance sees exactly the N=3 stimulus.
    assign if3n.in_valid  = if3.in_valid;
    assign if3n.in_data   = if3.in_data;
    assign if3n.in_desc   = if3.in_desc;
    assign if3n.out_ready = if3.out_ready;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic res_t model9(input logic [71:0] w, input logic d);
        logic [7:0] a [9];
        logic [7:0] t;
        res_t r;
        for (int i = 0; i < 9; i++) a[i] = w[i*8 +: 8];
        for (int i = 1; i < 9; i++) begin
            for (int j = i; j > 0 && a[j-1] > a[j]; j--) begin
                t = a[j]; a[j] = a[j-1]; a[j-1] = t;
            end
        end
        r.mn = a[0];
        r.md = a[4];
        r.mx = a[8];
        for (int i = 0; i < 9; i++) r.data[i*8 +: 8] = d ? a[8-i] : a[i];
        return r;
    endfunction

    task automatic send3(input string tag, input logic [23:0] w, input logic d,
                         input logic [23:0] ed, input logic [7:0] mn,
                         input logic [7:0] md, input logic [7:0] mx);
        int lat;
        if3.in_data   = w;
        if3.in_desc   = d;
        if3.in_valid  = 1'b1;
        if3.out_ready = 1'b1;
        @(posedge clk); #1;
        if3.in_valid = 1'b0;
        lat = 1;
        while (!if3.out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_lat"}, lat, 3);
        check({tag, "_data"}, if3.out_data, ed);
        check({tag, "_min"}, if3.out_min, mn);
        check({tag, "_med"}, if3.out_med, md);
        check({tag, "_max"}, if3.out_max, mx);
    endtask

    task automatic run9(input string tag, input int n_in, input int max_cyc, input bit bp);
        res_t        q [$];
        res_t        r;
        logic [95:0] rnd;
        int          sent = 0;
        int          got  = 0;
        int          cyc  = 0;
        bit          in_fire;
        bit          out_fire;
        while ((sent < n_in || q.size() != 0) && cyc < max_cyc) begin
            rnd = {$urandom, $urandom, $urandom};
            if9.in_valid  = (sent < n_in) && (bp ? ($urandom_range(0, 3) != 0) : 1'b1);
            if9.in_data   = rnd[71:0];
            if9.in_desc   = 1'($urandom_range(0, 1));
            if9.out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            check({tag, "_rdy"}, if9.in_ready, !if9.out_valid || if9.out_ready);
            if (if9.out_valid) begin
                if (q.size() == 0) begin
                    check({tag, "_spurious"}, 1'b1, 1'b0);
                end else begin
                    check({tag, "_data"}, if9.out_data, q[0].data);
                    check({tag, "_min"}, if9.out_min, q[0].mn);
                    check({tag, "_med"}, if9.out_med, q[0].md);
                    check({tag, "_max"}, if9.out_max, q[0].mx);
                end
            end
            in_fire  = if9.in_valid && if9.in_ready;
            out_fire = if9.out_valid && if9.out_ready && (q.size() != 0);
            r = model9(if9.in_data, if9.in_desc);
            @(posedge clk); #1;
            cyc++;
            if (out_fire) begin
                void'(q.pop_front());
                got++;
            end
            if (in_fire) begin
                q.push_back(r);
                sent++;
            end
        end
        if9.in_valid  = 1'b0;
        if9.out_ready = 1'b1;
        check({tag, "_count"}, got, n_in);
        if (!bp) check({tag, "_cycles"}, cyc, n_in + 9);
    endtask

    initial begin
        rst = 1'b1;
        if3.in_valid = 1'b1; if3.in_data = {8'd1, 8'd2, 8'd3}; if3.in_desc = 1'b0; if3.out_ready = 1'b1;
        if5.in_valid = 1'b0; if5.in_data = '0; if5.in_desc = 1'b0; if5.out_ready = 1'b1;
        if9.in_valid = 1'b0; if9.in_data = '0; if9.in_desc = 1'b0; if9.out_ready = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        check("rst_vld3", if3.out_valid, 1'b0);
        check("rst_data3", if3.out_data, 24'd0);
        check("rst_mmm3", {if3.out_min, if3.out_med, if3.out_max}, 24'd0);
        check("rst_rdy3", if3.in_ready, 1'b1);
        check("rst_vld9", if9.out_valid, 1'b0);
        check("rst_data9", if9.out_data, 72'd0);
        rst = 1'b0;
        if3.in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("rst_no_xfer", if3.out_valid, 1'b0);

        send3("asc", {8'd12, 8'd5, 8'd20}, 1'b0, {8'd20, 8'd12, 8'd5}, 8'd5, 8'd12, 8'd20);
        send3("eq", {8'd9, 8'd9, 8'd9}, 1'b0, {8'd9, 8'd9, 8'd9}, 8'd9, 8'd9, 8'd9);
        send3("zmz", {8'd0, 8'd255, 8'd0}, 1'b0, {8'd255, 8'd0, 8'd0}, 8'd0, 8'd0, 8'd255);
        send3("zmz_d", {8'd0, 8'd255, 8'd0}, 1'b1, {8'd0, 8'd0, 8'd255}, 8'd0, 8'd0, 8'd255);
        check("ascn_vld", if3n.out_valid, 1'b1);
        check("ascn_data", if3n.out_data, {8'd255, 8'd0, 8'd0});
        check("ascn_minmax", {if3n.out_min, if3n.out_max}, {8'd0, 8'd255});

        begin : n5_desc
            int lat;
            if5.in_data  = {8'd128, 8'd7, 8'd0, 8'd255, 8'd7};
            if5.in_desc  = 1'b1;
            if5.in_valid = 1'b1;
            @(posedge clk); #1;
            if5.in_valid = 1'b0;
            lat = 1;
            while (!if5.out_valid && lat < 20) begin
                @(posedge clk); #1;
                lat++;
            end
            check("n5_lat", lat, 5);
            check("n5_data", if5.out_data, {8'd0, 8'd7, 8'd7, 8'd128, 8'd255});
            check("n5_mmm", {if5.out_min, if5.out_med, if5.out_max}, {8'd0, 8'd7, 8'd255});
        end

        // Fill the N=3 pipe while stalled, then reset with three windows in flight.
        if3.out_ready = 1'b0;
        if3.in_desc   = 1'b0;
        if3.in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if3.in_data = {8'(i), 8'(i + 10), 8'(i + 20)};
            @(posedge clk); #1;
        end
        if3.in_valid = 1'b0;
        check("full_vld", if3.out_valid, 1'b1);
        check("full_rdy", if3.in_ready, 1'b0);
        check("full_data", if3.out_data, {8'd20, 8'd10, 8'd0});
        rst = 1'b1;
        #1;
        check("midrst_vld", if3.out_valid, 1'b0);
        check("midrst_data", if3.out_data, 24'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        send3("post_rst", {8'd1, 8'd2, 8'd3}, 1'b0, {8'd3, 8'd2, 8'd1}, 8'd1, 8'd2, 8'd3);

        run9("thru9", 1000, 5000, 1'b0);
        run9("bp9", 300, 5000, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sortn_pipe.md
SORTN_PIPE -- requirements
Module: sortn_pipe

Interface
REQ-001 SHALL have parameter DATA_W, default 8, unsigned element width (range 2..16).
REQ-002 SHALL have parameter N, default 3, element count (odd, range 3..9).
REQ-003 SHALL have parameter DESCEND_EN, default 1; 0 removes the descending-order mode hardware.
REQ-004 clk  input  1  single clock, all state updates on its rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 in_valid  input  1  in_data carries a window to sort.
REQ-007 in_ready  output  1  block accepts in_data this cycle.
REQ-008 in_data  input  N*DATA_W  element k in bits [k*DATA_W +: DATA_W].
REQ-009 in_desc  input  1  sampled with in_data: 0 = ascending, 1 = descending; ignored when DESCEND_EN=0.
REQ-010 out_valid  output  1  out_* hold a sorted result.
REQ-011 out_ready  input  1  downstream consumes the result this cycle.
REQ-012 out_data  output  N*DATA_W  sorted elements, element 0 first in the selected order.
REQ-013 out_min, out_med, out_max  output  DATA_W each  minimum, median (element (N-1)/2 ascending), maximum; these are independent of the order mode.

Function
REQ-014 SHALL sort with an odd-even transposition network of N stages: even stages compare pairs (0,1),(2,3)..., odd stages compare pairs (1,2),(3,4)...; the last element passes through unchanged where it is unpaired.
REQ-015 SHALL register every stage; latency SHALL be exactly N cycles from accepted input to out_valid when there is no stall.
REQ-016 Comparison SHALL be unsigned, on full DATA_W bits; equal elements SHALL NOT be swapped.
REQ-017 Ascending mode: the lower value SHALL go to the lower index; descending mode SHALL apply the reverse. in_desc SHALL travel down the pipe with its data.
REQ-018 out_min/out_max SHALL be chosen from the end elements of the final stage according to the travelling mode bit, so they are correct in both modes.
REQ-019 Handshake: a transfer SHALL occur when valid&&ready; advance = !out_valid || out_ready; in_ready = advance.
REQ-020 When advance=0 all stage registers and valid bits SHALL hold; out_* SHALL stay stable while out_valid=1 and out_ready=0.
REQ-021 A valid bit SHALL propagate per stage; a bubble (in_valid=0 while advancing) SHALL enter as valid=0; data registers of invalid stages are don't-care.
REQ-022 Full throughput: with out_ready held at 1, one result per cycle SHALL be produced for back-to-back inputs, in input order.
REQ-023 Simultaneous out_ready and a new in_valid in a stalled-full pipe SHALL shift by exactly one stage with no loss or duplication.

Reset
REQ-024 While rst=1, all stage valid bits and out_valid SHALL be 0, and out_data, out_min, out_med and out_max SHALL be 0.
REQ-025 in_ready SHALL be 1 while rst=1 (combinational from out_valid=0), but no transfer SHALL be recorded during reset.
REQ-026 Reset asserted mid-operation SHALL discard all in-flight windows; the first input after deassertion SHALL emerge after N cycles.

Structure
REQ-027 Package sort_pkg SHALL hold the DATA_W/N defaults, the legality checks (N odd, 3..9) and the stage-count function.
REQ-028 One sub-module, cmp_swap (DATA_W, descending-select input, two in and two out, combinational), SHALL be instantiated per comparator; registers stay in sortn_pipe.
REQ-029 Illegal N SHALL cause an elaboration error.

Verification
REQ-030 N=3, DATA_W=8, ascending: in {20,5,12} -> after 3 cycles out_data {5,12,20}, min 5, med 12, max 20.
REQ-031 N=5, descending: in {7,255,0,7,128} -> out_data {255,128,7,7,0}, min 0, med 7, max 255.
REQ-032 N=9: 1000 random windows back-to-back with out_ready=1 -> one result per cycle, in order, each matching the reference model.
REQ-033 Backpressure: drive out_ready with a random 50% pattern -> no lost or duplicated results, out_* stable while stalled, and in_ready tracks the advance rule.
REQ-034 Assert rst for one cycle with 3 windows in flight -> out_valid=0 at once; the next window emerges exactly N cycles after acceptance.
REQ-035 All-equal window {9,9,9} and window {0,255,0} -> out_data {9,9,9} and {0,0,255}.
